// File: rtl/enc_pkg.sv
// Shared constants for the encoder result capture path: entry layout,
// channel IDs and the saturating drop-counter helper.
package enc_pkg;

  localparam int ENC_CNT_W   = 64;
  localparam int ENC_TAG_W   = 2;
  localparam int ENC_ENTRY_W = ENC_CNT_W + ENC_TAG_W;
  localparam int DROP_W      = 16;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // Entry layout is {ovf, ch, cnt}: overflow at the MSB, channel ID just below.
  function automatic int ovf_pos(input int cnt_w);
    return cnt_w + 1;
  endfunction

  function automatic int ch_pos(input int cnt_w);
    return cnt_w;
  endfunction

  function automatic logic [DROP_W-1:0] drop_sat_add(input logic [DROP_W-1:0] cnt,
                                                     input logic [1:0]        inc);
    logic [DROP_W:0] sum;
    sum = {1'b0, cnt} + {{(DROP_W-1){1'b0}}, inc};
    if (sum[DROP_W]) begin
      drop_sat_add = {DROP_W{1'b1}};
    end else begin
      drop_sat_add = sum[DROP_W-1:0];
    end
  endfunction

endpackage

// File: rtl/enc_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO with a registered head
// entry; full/empty come from the occupancy count.
module enc_sync_fifo
  import enc_pkg::*;
#(
  parameter int  ENTRY_W = ENC_ENTRY_W,
  parameter int  DEPTH   = 16,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int LVL_W   = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               valid,
  output logic [LVL_W-1:0]   level,
  output logic [LVL_W-1:0]   level_nxt,
  output logic               full,
  output logic               empty
);

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_inc_s;
  logic [LVL_W-1:0]   level_r;
  logic [LVL_W-1:0]   level_nxt_s;
  logic [ENTRY_W-1:0] head_r;
  logic [ENTRY_W-1:0] head_nxt_s;
  logic               valid_r;
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;

  assign full_s       = (level_r == LVL_W'(DEPTH));
  assign empty_s      = (level_r == LVL_W'(0));
  assign pop_s        = rd_en && !empty_s && !flush;
  // A full FIFO still accepts a write when the head is leaving in the same cycle.
  assign push_s       = wr_en && !flush && (!full_s || pop_s);
  assign rd_ptr_inc_s = rd_ptr_r + PTR_W'(1);

  // Next occupancy and next head entry.
  always_comb begin
    level_nxt_s = level_r;
    head_nxt_s  = head_r;
    if (flush) begin
      level_nxt_s = LVL_W'(0);
    end else if (push_s && !pop_s) begin
      level_nxt_s = level_r + LVL_W'(1);
    end else if (pop_s && !push_s) begin
      level_nxt_s = level_r - LVL_W'(1);
    end else begin
      level_nxt_s = level_r;
    end
    if (pop_s && (level_r > LVL_W'(1))) begin
      head_nxt_s = mem_r[rd_ptr_inc_s];
    end else if (push_s && (empty_s || (pop_s && (level_r == LVL_W'(1))))) begin
      head_nxt_s = wr_data;
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Pointers, occupancy and the registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
      head_r   <= {ENTRY_W{1'b0}};
      valid_r  <= 1'b0;
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_inc_s;
      end
      level_r <= level_nxt_s;
      head_r  <= head_nxt_s;
      valid_r <= (level_nxt_s != LVL_W'(0));
    end
  end

  // Storage array; contents are only meaningful behind the level count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign rd_data   = head_r;
  assign valid     = valid_r;
  assign level     = level_r;
  assign level_nxt = level_nxt_s;
  assign full      = full_s;
  assign empty     = empty_s;

endmodule

// File: rtl/enc_result_fifo.sv
// Captures each encoder channel on its ready rising edge and queues the
// snapshot, tagged with its channel, into a shared FIFO for software.
module enc_result_fifo
  import enc_pkg::*;
#(
  parameter int  DEPTH      = 16,
  parameter int  CNT_W      = ENC_CNT_W,
  parameter int  IRQ_THRESH = 1,
  localparam int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [CNT_W-1:0]  I_CNT_A0,
  input  logic [CNT_W-1:0]  I_CNT_A1,
  input  logic              I_READY_0,
  input  logic              I_READY_1,
  input  logic              I_OVERFLOW_0,
  input  logic              I_OVERFLOW_1,
  input  logic              I_RD_EN,
  input  logic              I_CLR,
  output logic              O_VALID,
  output logic [CNT_W-1:0]  O_DATA,
  output logic              O_CH,
  output logic              O_OVF,
  output logic [LVL_W-1:0]  O_LEVEL,
  output logic [DROP_W-1:0] O_DROP_CNT,
  output logic              O_IRQ
);

  localparam int ENTRY_W = CNT_W + ENC_TAG_W;
  localparam int OVF_POS = ovf_pos(CNT_W);
  localparam int CH_POS  = ch_pos(CNT_W);

  logic               rdy_q_0_r, rdy_q_1_r;
  logic [CNT_W:0]     hold_0_r, hold_1_r;
  logic               pend_0_r, pend_1_r;
  logic [DROP_W-1:0]  drop_cnt_r, drop_nxt_s;
  logic               irq_r, irq_nxt_s;
  logic               cap_0_s, cap_1_s;
  logic               cap_drop_0_s, cap_drop_1_s;
  logic               wr_0_s, wr_1_s;
  logic               wr_req_s, pop_s, full_drop_s;
  logic [1:0]         drop_inc_s;
  logic [ENTRY_W-1:0] wr_data_s;
  logic [ENTRY_W-1:0] fifo_rd_data_s;
  logic [LVL_W-1:0]   fifo_level_nxt_s;
  logic               fifo_full_s, fifo_empty_s;

  assign cap_0_s = I_READY_0 && !rdy_q_0_r;
  assign cap_1_s = I_READY_1 && !rdy_q_1_r;
  // A sample arriving while its channel's previous one is still held is lost.
  assign cap_drop_0_s = cap_0_s && pend_0_r && !I_CLR;
  assign cap_drop_1_s = cap_1_s && pend_1_r && !I_CLR;

  assign wr_0_s      = pend_0_r;
  assign wr_1_s      = pend_1_r && !pend_0_r;
  assign wr_req_s    = (pend_0_r || pend_1_r) && !I_CLR;
  assign pop_s       = I_RD_EN && !fifo_empty_s;
  assign full_drop_s = wr_req_s && fifo_full_s && !pop_s;
  assign drop_inc_s  = {1'b0, cap_drop_0_s} + {1'b0, cap_drop_1_s} + {1'b0, full_drop_s};

  // Fixed-priority write mux, drop-count and interrupt next state.
  always_comb begin
    wr_data_s  = {hold_1_r[CNT_W], CH1, hold_1_r[CNT_W-1:0]};
    drop_nxt_s = drop_cnt_r;
    irq_nxt_s  = 1'b0;
    if (pend_0_r) begin
      wr_data_s = {hold_0_r[CNT_W], CH0, hold_0_r[CNT_W-1:0]};
    end else begin
      wr_data_s = {hold_1_r[CNT_W], CH1, hold_1_r[CNT_W-1:0]};
    end
    if (I_CLR) begin
      drop_nxt_s = {DROP_W{1'b0}};
      irq_nxt_s  = 1'b0;
    end else begin
      drop_nxt_s = drop_sat_add(drop_cnt_r, drop_inc_s);
      irq_nxt_s  = (fifo_level_nxt_s >= LVL_W'(IRQ_THRESH)) ||
                   (drop_nxt_s != {DROP_W{1'b0}});
    end
  end

  // Edge detect, capture holds and pending flags for both channels.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rdy_q_0_r <= 1'b0;
      rdy_q_1_r <= 1'b0;
      hold_0_r  <= {(CNT_W+1){1'b0}};
      hold_1_r  <= {(CNT_W+1){1'b0}};
      pend_0_r  <= 1'b0;
      pend_1_r  <= 1'b0;
    end else begin
      rdy_q_0_r <= I_READY_0;
      rdy_q_1_r <= I_READY_1;
      if (I_CLR) begin
        pend_0_r <= 1'b0;
      end else if (cap_0_s && !pend_0_r) begin
        hold_0_r <= {I_OVERFLOW_0, I_CNT_A0};
        pend_0_r <= 1'b1;
      end else if (wr_0_s) begin
        pend_0_r <= 1'b0;
      end
      if (I_CLR) begin
        pend_1_r <= 1'b0;
      end else if (cap_1_s && !pend_1_r) begin
        hold_1_r <= {I_OVERFLOW_1, I_CNT_A1};
        pend_1_r <= 1'b1;
      end else if (wr_1_s) begin
        pend_1_r <= 1'b0;
      end
    end
  end

  // Drop counter and interrupt level.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      drop_cnt_r <= {DROP_W{1'b0}};
      irq_r      <= 1'b0;
    end else begin
      drop_cnt_r <= drop_nxt_s;
      irq_r      <= irq_nxt_s;
    end
  end

  enc_sync_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RSTN),
    .flush     (I_CLR),
    .wr_en     (wr_req_s),
    .wr_data   (wr_data_s),
    .rd_en     (I_RD_EN),
    .rd_data   (fifo_rd_data_s),
    .valid     (O_VALID),
    .level     (O_LEVEL),
    .level_nxt (fifo_level_nxt_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign O_DATA     = fifo_rd_data_s[CNT_W-1:0];
  assign O_CH       = fifo_rd_data_s[CH_POS];
  assign O_OVF      = fifo_rd_data_s[OVF_POS];
  assign O_DROP_CNT = drop_cnt_r;
  assign O_IRQ      = irq_r;

endmodule

// File: doc/enc_result_fifo.md
Name: enc_result_fifo

Overview:
Downstream capture stage for the dual-channel encoder counter block. It snapshots each channel's 64-bit count and overflow flag on the rising edge of that channel's ready flag, and queues the snapshots into one shared FIFO tagged with the channel ID. Software drains the FIFO through a valid/read handshake from the AXI register front end. An interrupt is raised on a programmable fill level or when samples are lost.

Parameters:
DEPTH, 16, FIFO entries (power of two, >=4)
CNT_W, 64, counter width
IRQ_THRESH, 1, fill level (1..DEPTH) that asserts O_IRQ

Ports:
CLK  in  1  single clock, same domain as the counter block
RSTN  in  1  asynchronous active-low reset
I_CNT_A0  in  CNT_W  channel 0 count
I_CNT_A1  in  CNT_W  channel 1 count
I_READY_0  in  1  channel 0 result-ready level
I_READY_1  in  1  channel 1 result-ready level
I_OVERFLOW_0  in  1  channel 0 overflow flag
I_OVERFLOW_1  in  1  channel 1 overflow flag
I_RD_EN  in  1  pop request from the register front end
I_CLR  in  1  synchronous single-cycle flush/clear pulse
O_VALID  out  1  head entry valid
O_DATA  out  CNT_W  head count
O_CH  out  1  head channel ID
O_OVF  out  1  head overflow flag
O_LEVEL  out  log2(DEPTH)+1  current entry count
O_DROP_CNT  out  16  lost-sample counter, saturating
O_IRQ  out  1  interrupt level

Behaviour:
- Reset (RSTN low, asynchronous): O_VALID=0, O_DATA=0, O_CH=0, O_OVF=0, O_LEVEL=0, O_DROP_CNT=0, O_IRQ=0. Edge-detect registers, hold registers, and pending flags are all 0. Reset mid-operation discards all contents.
- Edge detect: rdy_q_x registers I_READY_x. A capture for channel x fires in a cycle where I_READY_x=1 and rdy_q_x=0. A level held high captures once only.
- Capture: at the clock edge where the capture fires, hold_x <= {I_OVERFLOW_x, I_CNT_Ax} and pend_x <= 1.
- Capture while pend_x is still 1: the new sample is dropped, hold_x keeps the old value, and O_DROP_CNT increments.
- Write arbiter: at most one FIFO write per cycle. Channel 0 has fixed priority. If pend_0, write {ovf, ch=0, cnt}; else if pend_1, write with ch=1. The written channel's pend is cleared at that edge.
- Full: a write attempted while the FIFO is full and no pop occurs in the same cycle is discarded. Its pend is still cleared, and O_DROP_CNT increments.
- Full with a simultaneous pop: the write succeeds and O_LEVEL is unchanged.
- O_DROP_CNT: saturates at 16'hFFFF. Two drop events in one cycle add 2, still saturating.
- Latency, single channel capture at edge k: write at edge k+1, O_VALID=1 after edge k+1 if the FIFO was empty (first-word fall-through).
- Latency, simultaneous capture of both channels: channel 0 visible after k+1, channel 1 written at k+2.
- Read: a pop occurs when O_VALID && I_RD_EN. I_RD_EN while O_VALID=0 is ignored, with no underflow. O_DATA/O_CH/O_OVF show the new head on the cycle after a pop. They hold their value while no pop occurs.
- O_LEVEL: registered, +1 on write, -1 on pop, unchanged on write+pop in the same cycle.
- O_IRQ: registered. Value is (O_LEVEL_next >= IRQ_THRESH) || (drop_cnt_next != 0). It falls once the FIFO drains below the threshold and the drop count is 0.
- I_CLR: at the edge where it is sampled, empty the FIFO, set O_DROP_CNT=0, clear pend_0/pend_1, and set O_VALID=0, O_IRQ=0. Captures firing in the same cycle are discarded. rdy_q_x still update, so a ready level already high does not re-trigger.
- Pointers: log2(DEPTH)-bit pointers that wrap naturally. Full/empty are derived from O_LEVEL.

Decomposition:
- Package enc_pkg: CNT_W default, ENTRY_W = CNT_W+2, field positions (OVF at MSB, CH next, CNT below), and channel ID constants CH0=0/CH1=1.
- Sub-module enc_sync_fifo: generic first-word-fall-through synchronous FIFO (ENTRY_W, DEPTH) with wr_en/rd_en/flush/level/full/empty.
- Capture, arbitration, drop counter and IRQ logic live in enc_result_fifo.

Test Plan:
- Single capture: I_CNT_A0=64'h1234, I_READY_0 rises at edge k -> O_VALID=1 after k+1, O_DATA=64'h1234, O_CH=0, O_OVF=0, O_LEVEL=1, O_IRQ=1. Pop -> O_VALID=0, O_IRQ=0.
- Simultaneous: both ready flags rise with A0=5, A1=9, OVERFLOW_1=1 -> pops return (ch0,5,ovf0) then (ch1,9,ovf1), and O_LEVEL peaks at 2.
- Overflow of FIFO: 17 alternating channel-0 ready pulses with DEPTH=16 and no reads -> O_LEVEL=16, O_DROP_CNT=1, first 16 counts preserved in order.
- Full with simultaneous write and pop: fill to 16, then a capture coinciding with I_RD_EN -> no drop, O_LEVEL stays 16, new entry at the tail.
- I_CLR in the same cycle as a capture edge, with 3 entries queued and a drop count of 2 -> O_LEVEL=0, O_DROP_CNT=0, O_VALID=0, O_IRQ=0, and the held-high ready does not re-capture.
- Asynchronous reset asserted mid-stream between clock edges -> all outputs 0 immediately. After release, the first new ready edge is stored as the sole entry.
